// File: rtl/ucode_pkg.sv
// Shared types and constants for the microcode sequencer.
// State encoding, fetch-phase control word and unit channel indices.
package ucode_pkg;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_LATCH_IR = 3'd1,
    ST_DECODE   = 3'd2,
    ST_WAIT     = 3'd3,
    ST_EVENT    = 3'd4
  } state_e;

  // Handshake channel indices
  localparam int UNIT_MEM = 0;
  localparam int UNIT_ALU = 1;

  // Control flag bit positions used by the fetch control word
  localparam int PCC_FLAG_BIT  = 20;
  localparam int ROMO_FLAG_BIT = 21;

  // Control word presented while an opcode is being fetched:
  // increment the PC and enable the program ROM onto the bus.
  localparam logic [21:0] FETCH_FLAGS =
    22'((32'd1 << PCC_FLAG_BIT) | (32'd1 << ROMO_FLAG_BIT));

endpackage

// File: rtl/ucode_seq.sv
// Microcode sequencer: fetches an opcode, walks its micro-phases through an
// external microcode ROM, handshakes with execution units and strobes an
// event at the end of each phase.
// Optional feature macro: SEQ_TIMEOUT_EN (adds wait timer and seq_err port).
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_FETCH    | request opcode from the memory unit, wait for its done edge
// ST_LATCH_IR | capture fetched opcode, restart at phase 0
// ST_DECODE   | apply ROM word: optional PC increment, load unit requests
// ST_WAIT     | service pending units lowest index first
// ST_EVENT    | one-cycle phase strobe; next phase or back to fetch
module ucode_seq
  import ucode_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int NUM_UNITS  = 2,
  parameter int FLAG_W     = 22,
  parameter int PC_W       = 16,
  parameter int PCC_BIT    = 20
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_W  = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [NUM_UNITS-1:0] unit_exec,
  input  logic [7:0]           irin,
  output logic [7:0]           ucode_ir,
  output logic [2:0]           ucode_phase,
  input  logic [FLAG_W-1:0]    ucode_flags,
  input  logic [NUM_UNITS-1:0] ucode_units,
  input  logic                 ucode_last,
  input  logic                 pcinflag,
  input  logic [PC_W-1:0]      pcin,
  output logic [PC_W-1:0]      pc,
  output logic [FLAG_W-1:0]    flags,
  output logic [FLAG_W-1:0]    flags_noc,
  output logic                 phase_event,
  output logic [2:0]           event_phase
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic                 seq_err
`endif
);

  localparam logic [FLAG_W-1:0]    FETCH_FLAGS_W = FLAG_W'(FETCH_FLAGS);
  localparam logic [2:0]           LAST_PHASE    = 3'(NUM_PHASES - 1);
  localparam logic [NUM_UNITS-1:0] ONE_U         = NUM_UNITS'(1);
  localparam logic [PC_W-1:0]      ONE_PC        = PC_W'(1);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [7:0]           ir_q, ir_d;
  logic [2:0]           phase_q, phase_d;
  logic [NUM_UNITS-1:0] pending_q, pending_d;
  logic [NUM_UNITS-1:0] done_q, done_d;

  logic [NUM_UNITS-1:0] rise;
  logic [NUM_UNITS-1:0] svc_oh;
  logic                 svc_edge;
  logic                 timeout;

  // Edge detect against the registered done levels; isolate lowest pending unit
  always_comb begin
    rise     = unit_done & ~done_q;
    svc_oh   = pending_q & (~pending_q + ONE_U);
    svc_edge = |(svc_oh & rise);
    done_d   = unit_done;
  end

`ifdef SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 seq_err_q, seq_err_d;

  // Wait timer: runs while fetching or waiting, restarts on every serviced edge
  always_comb begin
    timer_d   = timer_q;
    seq_err_d = seq_err_q;
    timeout   = 1'b0;
    if (state_q == ST_FETCH || state_q == ST_WAIT) begin
      timeout = &timer_q;
      if (timeout) begin
        seq_err_d = 1'b1;
        timer_d   = '0;
      end else if ((state_q == ST_FETCH && rise[UNIT_MEM]) ||
                   (state_q == ST_WAIT && svc_edge)) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + TIMEOUT_W'(1);
      end
    end
  end

  // Timer and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      seq_err_q <= 1'b0;
    end else if (!halt) begin
      timer_q   <= timer_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  // Without the timer every wait is unbounded
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    phase_d     = phase_q;
    pending_d   = pending_q;
    unit_exec   = '0;
    flags_noc   = ucode_flags;
    flags       = '0;
    phase_event = 1'b0;

    case (state_q)
      ST_FETCH: begin
        unit_exec[UNIT_MEM] = done_q[UNIT_MEM];
        flags_noc           = FETCH_FLAGS_W;
        if (rise[UNIT_MEM] || timeout) begin
          state_d = ST_LATCH_IR;
        end
      end

      ST_LATCH_IR: begin
        flags_noc = FETCH_FLAGS_W;
        ir_d      = irin;
        phase_d   = '0;
        state_d   = ST_DECODE;
      end

      ST_DECODE: begin
        if (ucode_flags[PCC_BIT]) begin
          pc_d = pc_q + ONE_PC;
        end
        pending_d = ucode_units;
        state_d   = (|ucode_units) ? ST_WAIT : ST_EVENT;
      end

      ST_WAIT: begin
        unit_exec = svc_oh & done_q;
        if (pending_q == '0) begin
          state_d = ST_EVENT;
        end else if (svc_edge || timeout) begin
          pending_d = pending_q & ~svc_oh;
          if (pending_d == '0) begin
            state_d = ST_EVENT;
          end
        end
      end

      ST_EVENT: begin
        phase_event = 1'b1;
        if (ucode_last || phase_q == LAST_PHASE) begin
          state_d = ST_FETCH;
          pc_d    = pcinflag ? pcin : (pc_q + ONE_PC);
        end else begin
          phase_d = phase_q + 3'd1;
          state_d = ST_DECODE;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (state_q == ST_FETCH || state_q == ST_LATCH_IR || state_q == ST_EVENT) begin
      flags = flags_noc;
    end
  end

  // Sequencer state registers; halt freezes everything, reset wins over halt
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      phase_q   <= '0;
      pending_q <= '0;
      done_q    <= '1;
    end else if (!halt) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  // ROM address and status outputs
  always_comb begin
    pc          = pc_q;
    ucode_ir    = ir_q;
    ucode_phase = phase_q;
    event_phase = phase_q;
  end

endmodule
